vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Parametrised successor to the fixed 4-interface VRAM priority mux. It arbitrates one 8-bit CPU port (read/write, byte-lane write patterns) and NUM_RD 32-bit read-only fetch ports onto a single external 32-bit-wide single-port RAM with 1-cycle read latency. The CPU port has fixed highest priority. Read ports share fairly through a round-robin pointer, replacing the old fixed priority. It sits between the bus/DMA front-end and the main RAM, feeding the layer and sprite renderers.

Parameters:
NUM_RD, 3, number of 32-bit read-only ports (1..8)
ADDR_W, 15, RAM word-address width; CPU byte address is ADDR_W+2 bits
MAX_WAIT, 4, consecutive CPU-won cycles tolerated before a pending read port is forced through (only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_addr  in  ADDR_W+2  CPU byte address
cpu_wrpattern  in  2  write byte-lane pattern select
cpu_wrdata  in  8  write byte, replicated to all 4 lanes
cpu_write  in  1  1 = write, 0 = read
cpu_strobe  in  1  request; held until cpu_ack
cpu_ack  out  1  access completed (1 cycle after grant)
cpu_rddata  out  8  read byte
rd_addr  in  NUM_RD*ADDR_W  packed word addresses; port i at [i*ADDR_W +: ADDR_W]
rd_strobe  in  NUM_RD  per-port request; held until ack
rd_ack  out  NUM_RD  per-port completion, one-hot or zero
rd_rddata  out  32  shared read data, valid in the rd_ack cycle
ram_addr  out  ADDR_W  RAM word address
ram_wrdata  out  32  {4{cpu_wrdata}}
ram_wrbytesel  out  4  byte-lane write enables
ram_write  out  1  RAM write strobe
ram_rddata  in  32  RAM read data, 1 cycle after address

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; ports are named clk and reset.
- Grant is combinational each cycle, at most one requester:
  - CPU wins if cpu_strobe is high.
  - Otherwise the first asserted rd_strobe at or after rr_ptr (modulo NUM_RD) wins.
  - No request: ram_addr=0, ram_write=0.
- Round-robin pointer: after a read grant to port i, rr_ptr <= (i+1) mod NUM_RD. It is unchanged on CPU grants and idle cycles.
- RAM drive from a CPU grant: ram_addr = cpu_addr[ADDR_W+1:2]. ram_write = cpu_strobe & cpu_write, so writes are never granted to read ports.
- ram_wrbytesel, rows are pattern, columns are addr[1:0] = 0/1/2/3:
  - 00: 0001 0010 0100 1000
  - 01: 0011 0110 1100 1001
  - 10: 0101 1010 0111 1110
  - 11: 1111 1111 1101 1011
- Acks: cpu_ack and rd_ack[i] are registered one cycle after their grant, for both reads and writes. A requester holding its strobe across consecutive cycles is re-granted and gets back-to-back acks.
- rd_rddata = ram_rddata (pass-through), valid only when the matching rd_ack is high.
- CPU read byte:
  - Select from ram_rddata by cpu_addr[1:0] registered at grant.
  - hold_r <= selected byte when cpu_ack is high.
  - cpu_rddata = cpu_ack ? selected byte : hold_r.
- Reset values: cpu_ack=0, rd_ack=0, hold_r=0 (so cpu_rddata=0), rr_ptr=0, wait_cnt=0.
- Reset mid-access: a grant in the reset cycle produces no ack. ram_write is still combinational from the strobe, so the bus front-end must not strobe during reset.
- NUM_RD=1: rr_ptr is constant 0.

Optional Feature:
VRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A wait_cnt of $clog2(MAX_WAIT+1) bits increments each cycle that any rd_strobe is high and the CPU wins.
  - It clears on any read grant or when no rd_strobe is high.
  - When wait_cnt == MAX_WAIT, the round-robin read winner is granted over the CPU that cycle. cpu_ack is not asserted for that cycle and the CPU keeps its strobe held. wait_cnt then clears.
- Undefined: the CPU has absolute priority, no counter is built, and read ports can starve indefinitely.

Test Plan:
- Writes: CPU write cpu_addr=0x00006, pattern 01, data 0xA5 -> same cycle ram_addr=1, ram_wrbytesel=1100, ram_wrdata=0xA5A5A5A5, ram_write=1; next cycle cpu_ack=1.
- CPU read: RAM word 2 = 0x44332211, CPU read at byte address 0x0000B -> next cycle cpu_ack=1, cpu_rddata=0x44; cpu_rddata holds 0x44 after strobe drops.
- Round-robin: NUM_RD=3, all rd_strobe held high, no CPU request -> grants to ports 0,1,2,0,1,2 on consecutive cycles; rd_ack = 001,010,100,001.
- CPU priority: CPU and port 1 request together -> CPU acked first; port 1 acked the cycle after the CPU drops its strobe; rr_ptr unchanged by the CPU grant.
- Starvation guard (VRAM_ARB_STARVE_GUARD_EN, MAX_WAIT=4): CPU strobe held continuously, port 0 requesting -> 4 CPU acks, then rd_ack=001 with cpu_ack=0, then CPU acks resume. With the macro undefined, rd_ack stays 0.
- Reset: assert reset in the cycle after a grant -> following cycle all acks=0, cpu_rddata=0, rr_ptr=0.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: one 8-bit CPU port (fixed top priority) plus NUM_RD round-robin 32-bit read ports onto a single-port RAM.
// Optional starvation guard for the read ports is enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W+1:0]        cpu_addr,
    input  logic [1:0]               cpu_wrpattern,
    input  logic [7:0]               cpu_wrdata,
    input  logic                     cpu_write,
    input  logic                     cpu_strobe,
    output logic                     cpu_ack,
    output logic [7:0]               cpu_rddata,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_strobe,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [31:0]              rd_rddata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [31:0]              ram_wrdata,
    output logic [3:0]               ram_wrbytesel,
    output logic                     ram_write,
    input  logic [31:0]              ram_rddata
);

    localparam int unsigned PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_num_rd
        $error("vram_arbiter: NUM_RD must be in 1..8");
    end
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("vram_arbiter: MAX_WAIT must be at least 1");
    end

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_cpu_ack;
    logic [NUM_RD-1:0] r_rd_ack;
    logic [1:0]        r_byte_sel;
    logic [7:0]        r_hold;

    logic              w_hi_any;
    logic              w_lo_any;
    logic [PTR_W-1:0]  w_hi_idx;
    logic [PTR_W-1:0]  w_lo_idx;
    logic              w_rd_any;
    logic [PTR_W-1:0]  w_rd_idx;
    logic [PTR_W-1:0]  w_rr_next;
    logic [ADDR_W-1:0] w_rd_word;
    logic [NUM_RD-1:0] w_rd_gnt_vec;
    logic              w_force;
    logic              w_cpu_gnt;
    logic              w_rd_gnt;
    logic [3:0]        w_bytesel;
    logic [7:0]        w_cpu_byte;

    // Round-robin pick: lowest requester at/after the pointer, else lowest overall (wrap).
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = int'(NUM_RD) - 1; i >= 0; i--) begin
            if (rd_strobe[i]) begin
                w_lo_any = 1'b1;
                w_lo_idx = PTR_W'(i);
                if (PTR_W'(i) >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = PTR_W'(i);
                end
            end
        end
        w_rd_any = w_lo_any;
        w_rd_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (w_rd_idx == PTR_W'(i)) begin
                w_rd_word = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_rr_next = (w_rd_idx == PTR_W'(NUM_RD - 1)) ? '0 : w_rd_idx + PTR_W'(1);

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;

    // Counts consecutive cycles the CPU beat a waiting read port; at the limit the read port wins once.
    assign w_force = w_rd_any && (r_wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_rd_any && w_cpu_gnt) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_cpu_gnt = cpu_strobe && !w_force;
    assign w_rd_gnt  = w_rd_any && !w_cpu_gnt;

    always_comb begin
        w_rd_gnt_vec = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            w_rd_gnt_vec[i] = w_rd_gnt && (w_rd_idx == PTR_W'(i));
        end
    end

    // Byte-lane enables indexed by {pattern, byte offset}.
    always_comb begin
        w_bytesel = 4'b0000;
        case ({cpu_wrpattern, cpu_addr[1:0]})
            4'b00_00: w_bytesel = 4'b0001;
            4'b00_01: w_bytesel = 4'b0010;
            4'b00_10: w_bytesel = 4'b0100;
            4'b00_11: w_bytesel = 4'b1000;
            4'b01_00: w_bytesel = 4'b0011;
            4'b01_01: w_bytesel = 4'b0110;
            4'b01_10: w_bytesel = 4'b1100;
            4'b01_11: w_bytesel = 4'b1001;
            4'b10_00: w_bytesel = 4'b0101;
            4'b10_01: w_bytesel = 4'b1010;
            4'b10_10: w_bytesel = 4'b0111;
            4'b10_11: w_bytesel = 4'b1110;
            4'b11_00: w_bytesel = 4'b1111;
            4'b11_01: w_bytesel = 4'b1111;
            4'b11_10: w_bytesel = 4'b1101;
            4'b11_11: w_bytesel = 4'b1011;
            default:  w_bytesel = 4'b0000;
        endcase
    end

    assign ram_addr      = w_cpu_gnt ? cpu_addr[ADDR_W+1:2] : (w_rd_gnt ? w_rd_word : '0);
    assign ram_write     = w_cpu_gnt && cpu_write;
    assign ram_wrbytesel = ram_write ? w_bytesel : 4'b0000;
    assign ram_wrdata    = {4{cpu_wrdata}};

    always_comb begin
        w_cpu_byte = ram_rddata[7:0];
        case (r_byte_sel)
            2'd0:    w_cpu_byte = ram_rddata[7:0];
            2'd1:    w_cpu_byte = ram_rddata[15:8];
            2'd2:    w_cpu_byte = ram_rddata[23:16];
            default: w_cpu_byte = ram_rddata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_cpu_ack  <= 1'b0;
            r_rd_ack   <= '0;
            r_byte_sel <= 2'b00;
            r_hold     <= 8'h00;
        end else begin
            r_cpu_ack <= w_cpu_gnt;
            r_rd_ack  <= w_rd_gnt_vec;
            if (w_cpu_gnt) begin
                r_byte_sel <= cpu_addr[1:0];
            end
            if (r_cpu_ack) begin
                r_hold <= w_cpu_byte;
            end
            if (w_rd_gnt) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign cpu_ack    = r_cpu_ack;
    assign rd_ack     = r_rd_ack;
    assign cpu_rddata = r_cpu_ack ? w_cpu_byte : r_hold;
    assign rd_rddata  = ram_rddata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic, checked each cycle against a transaction-level model.
module tb_vram_arbiter;

    localparam int unsigned NUM_RD   = 3;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned NW       = 1 << ADDR_W;
    localparam int CPU  = -2;
    localparam int NONE = -1;

    localparam int P_RAM_ADDR = 0;
    localparam int P_BSEL     = 1;
    localparam int P_WDATA    = 2;
    localparam int P_WRITE    = 3;
    localparam int P_CPU_ACK  = 4;
    localparam int P_CPU_RD   = 5;
    localparam int P_RD_ACK   = 6;

    logic                     clk;
    logic                     reset;
    logic [ADDR_W+1:0]        cpu_addr;
    logic [1:0]               cpu_wrpattern;
    logic [7:0]               cpu_wrdata;
    logic                     cpu_write;
    logic                     cpu_strobe;
    logic                     cpu_ack;
    logic [7:0]               cpu_rddata;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_strobe;
    logic [NUM_RD-1:0]        rd_ack;
    logic [31:0]              rd_rddata;
    logic [ADDR_W-1:0]        ram_addr;
    logic [31:0]              ram_wrdata;
    logic [3:0]               ram_wrbytesel;
    logic                     ram_write;
    logic [31:0]              ram_rddata;

    vram_arbiter #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wrpattern(cpu_wrpattern), .cpu_wrdata(cpu_wrdata),
        .cpu_write(cpu_write), .cpu_strobe(cpu_strobe), .cpu_ack(cpu_ack), .cpu_rddata(cpu_rddata),
        .rd_addr(rd_addr), .rd_strobe(rd_strobe), .rd_ack(rd_ack), .rd_rddata(rd_rddata),
        .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
        .ram_write(ram_write), .ram_rddata(ram_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane-enable table, row = write pattern, column = byte offset.
    logic [3:0] lane_tab [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b0110, 4'b1100, 4'b1001,
        4'b0101, 4'b1010, 4'b0111, 4'b1110,
        4'b1111, 4'b1111, 4'b1101, 4'b1011
    };
    logic [2:0] rr_exp [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    function automatic logic [31:0] seed(int i);
        return (i == 2) ? 32'h4433_2211 : ((32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_0F1E);
    endfunction

    // External RAM: 1-cycle read latency, read-before-write on the same word.
    logic [31:0] ram [NW];
    initial begin
        for (int i = 0; i < int'(NW); i++) ram[i] = seed(i);
        ram_rddata = '0;
        forever begin
            @(posedge clk);
            ram_rddata <= ram[ram_addr];
            if (ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_wrbytesel[b]) ram[ram_addr][8*b +: 8] = ram_wrdata[8*b +: 8];
        end
    end

    // Reference model state: what each port should see, tracked per transaction.
    logic [31:0] m_mem [NW];
    int          m_rr = 0;
    int          m_wait = 0;
    bit          m_cpu_ack = 1'b0;
    int          m_rd_ack = NONE;
    logic [7:0]  m_cpu_byte = 8'h00;
    logic [7:0]  m_hold = 8'h00;
    logic [31:0] m_rd_word = 32'h0;

    function automatic int winner();
        bit force_rd;
        force_rd = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        force_rd = (rd_strobe != '0) && (m_wait == int'(MAX_WAIT));
`endif
        if (cpu_strobe && !force_rd) return CPU;
        for (int k = 0; k < int'(NUM_RD); k++)
            if (rd_strobe[(m_rr + k) % int'(NUM_RD)]) return (m_rr + k) % int'(NUM_RD);
        return NONE;
    endfunction

    initial begin
        for (int i = 0; i < int'(NW); i++) m_mem[i] = seed(i);
        forever begin
            int g;
            int w;
            int off;
            @(posedge clk);
            g = winner();
            w = int'(cpu_addr[ADDR_W+1:2]);
            off = int'(cpu_addr[1:0]);
            if (reset) begin
                m_rr = 0; m_wait = 0; m_cpu_ack = 1'b0; m_rd_ack = NONE; m_hold = 8'h00;
            end else begin
                if (m_cpu_ack) m_hold = m_cpu_byte;
                m_cpu_ack = (g == CPU);
                m_rd_ack  = (g >= 0) ? g : NONE;
                if (g == CPU) m_cpu_byte = m_mem[w][8*off +: 8];
                if (g >= 0) begin
                    m_rd_word = m_mem[rd_addr[g*ADDR_W +: ADDR_W]];
                    m_rr = (g + 1) % int'(NUM_RD);
                end
`ifdef VRAM_ARB_STARVE_GUARD_EN
                m_wait = ((rd_strobe != '0) && (g == CPU)) ? m_wait + 1 : 0;
`endif
            end
            if (g == CPU && cpu_write)
                for (int b = 0; b < 4; b++)
                    if (lane_tab[{cpu_wrpattern, cpu_addr[1:0]}][b]) m_mem[w][8*b +: 8] = cpu_wrdata;
        end
    end

    // Hand-computed literal expectations for the current cycle, set by the stimulus process.
    bit          chk_en = 1'b0;
    bit          pin_en   [8];
    int          pin_id   [8];
    logic [31:0] pin_exp  [8];
    string       pin_name [8];
    int          npin = 0;

    function automatic logic [31:0] sig(int id);
        case (id)
            P_RAM_ADDR: return 32'(ram_addr);
            P_BSEL:     return 32'(ram_wrbytesel);
            P_WDATA:    return ram_wrdata;
            P_WRITE:    return 32'(ram_write);
            P_CPU_ACK:  return 32'(cpu_ack);
            P_CPU_RD:   return 32'(cpu_rddata);
            default:    return 32'(rd_ack);
        endcase
    endfunction

    int n_vec;
    int n_bad;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Single compare process, away from the active edge.
    initial begin
        n_vec = 0;
        n_bad = 0;
        forever begin
            int g;
            logic [31:0] e_addr;
            @(negedge clk);
            if (chk_en) begin
                g = winner();
                e_addr = (g == CPU) ? 32'(cpu_addr[ADDR_W+1:2]) :
                         (g >= 0)   ? 32'(rd_addr[g*ADDR_W +: ADDR_W]) : 32'h0;
                check("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
                check("rd_ack", 32'(rd_ack), (m_rd_ack >= 0) ? (32'h1 << m_rd_ack) : 32'h0);
                if (m_rd_ack >= 0) check("rd_rddata", rd_rddata, m_rd_word);
                check("cpu_rddata", 32'(cpu_rddata), 32'(m_cpu_ack ? m_cpu_byte : m_hold));
                check("ram_addr", 32'(ram_addr), e_addr);
                check("ram_write", 32'(ram_write), 32'((g == CPU) && cpu_write));
                if ((g == CPU) && cpu_write) begin
                    check("ram_wrbytesel", 32'(ram_wrbytesel), 32'(lane_tab[{cpu_wrpattern, cpu_addr[1:0]}]));
                    check("ram_wrdata", ram_wrdata, {4{cpu_wrdata}});
                end
                for (int p = 0; p < 8; p++)
                    if (pin_en[p]) check(pin_name[p], sig(pin_id[p]), pin_exp[p]);
            end
        end
    end

    task automatic pin(int id, logic [31:0] exp, string name);
        pin_id[npin] = id; pin_exp[npin] = exp; pin_name[npin] = name; pin_en[npin] = 1'b1;
        npin++;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int p = 0; p < 8; p++) pin_en[p] = 1'b0;
        npin = 0;
        #1;
    endtask

    initial begin
        int cpu_rate;
        for (int p = 0; p < 8; p++) pin_en[p] = 1'b0;
        reset = 1'b1; cpu_addr = '0; cpu_wrpattern = 2'b00; cpu_wrdata = 8'h00;
        cpu_write = 1'b0; cpu_strobe = 1'b0; rd_addr = '0; rd_strobe = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        pin(P_CPU_ACK, 0, "reset_cpu_ack"); pin(P_RD_ACK, 0, "reset_rd_ack"); pin(P_CPU_RD, 0, "reset_cpu_rddata");
        tick();

        // CPU write: byte address 6, pattern 01
        cpu_addr = 17'h6; cpu_wrpattern = 2'b01; cpu_wrdata = 8'hA5; cpu_write = 1'b1; cpu_strobe = 1'b1;
        pin(P_RAM_ADDR, 1, "wr_ram_addr"); pin(P_BSEL, 32'b1100, "wr_bytesel");
        pin(P_WDATA, 32'hA5A5_A5A5, "wr_wrdata"); pin(P_WRITE, 1, "wr_ram_write");
        tick();
        cpu_strobe = 1'b0; cpu_write = 1'b0;
        pin(P_CPU_ACK, 1, "wr_cpu_ack");
        tick();

        // CPU read: byte 3 of word 2
        cpu_addr = 17'hB; cpu_strobe = 1'b1;
        tick();
        cpu_strobe = 1'b0;
        pin(P_CPU_ACK, 1, "rd_cpu_ack"); pin(P_CPU_RD, 32'h44, "rd_cpu_byte");
        tick();
        pin(P_CPU_ACK, 0, "rd_ack_drop"); pin(P_CPU_RD, 32'h44, "rd_cpu_hold");
        tick();

        // Reset the cycle after a read-port grant
        rd_addr[1*ADDR_W +: ADDR_W] = 15'd2; rd_strobe = 3'b010;
        tick();
        reset = 1'b1; rd_strobe = '0;
        pin(P_RD_ACK, 32'b010, "pre_reset_rd_ack");
        tick();
        reset = 1'b0;
        pin(P_CPU_ACK, 0, "post_reset_cpu_ack"); pin(P_RD_ACK, 0, "post_reset_rd_ack"); pin(P_CPU_RD, 0, "post_reset_cpu_rddata");
        tick();

        // Round-robin with all read ports requesting
        for (int i = 0; i < int'(NUM_RD); i++) rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(10 + i);
        rd_strobe = 3'b111;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) rd_strobe = '0;
            pin(P_RD_ACK, 32'(rr_exp[c]), "rr_rd_ack");
            tick();
        end

        // CPU beats port 1
        cpu_addr = 17'h10; cpu_strobe = 1'b1; rd_addr[1*ADDR_W +: ADDR_W] = 15'h123; rd_strobe = 3'b010;
        pin(P_RAM_ADDR, 4, "prio_addr_cpu"); pin(P_CPU_ACK, 0, "prio_c0_cpu_ack");
        tick();
        pin(P_CPU_ACK, 1, "prio_c1_cpu_ack"); pin(P_RD_ACK, 0, "prio_c1_rd_ack");
        tick();
        cpu_strobe = 1'b0;
        pin(P_CPU_ACK, 1, "prio_c2_cpu_ack"); pin(P_RAM_ADDR, 32'h123, "prio_addr_rd");
        tick();
        rd_strobe = '0;
        pin(P_RD_ACK, 32'b010, "prio_rd_ack"); pin(P_CPU_ACK, 0, "prio_c3_cpu_ack");
        tick();

        // CPU held continuously while port 0 waits
        cpu_addr = 17'h20; cpu_strobe = 1'b1; rd_strobe = 3'b001;
        tick();
        for (int c = 1; c <= 4; c++) begin
            pin(P_CPU_ACK, 1, "starve_cpu_ack"); pin(P_RD_ACK, 0, "starve_rd_ack");
            tick();
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        rd_strobe = '0;
        pin(P_RD_ACK, 32'b001, "guard_rd_ack"); pin(P_CPU_ACK, 0, "guard_cpu_ack");
`else
        pin(P_RD_ACK, 0, "noguard_rd_ack"); pin(P_CPU_ACK, 1, "noguard_cpu_ack");
`endif
        tick();
        cpu_strobe = 1'b0;
        pin(P_CPU_ACK, 1, "starve_resume_cpu_ack");
        tick();
`ifndef VRAM_ARB_STARVE_GUARD_EN
        rd_strobe = '0;
        pin(P_RD_ACK, 32'b001, "noguard_late_rd_ack");
`endif
        tick();
        tick();

        // Random traffic honouring the hold-until-ack handshake
        for (int c = 0; c < 4000; c++) begin
            cpu_rate = (c < 2000) ? 40 : 90;
            if (c % 997 == 996) begin
                reset = 1'b1; cpu_strobe = 1'b0; rd_strobe = '0;
            end else begin
                reset = 1'b0;
                if (!cpu_strobe || m_cpu_ack) begin
                    cpu_strobe = ($urandom_range(0, 99) < cpu_rate);
                    cpu_addr = {ADDR_W'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
                    cpu_write = 1'($urandom_range(0, 1));
                    cpu_wrpattern = 2'($urandom_range(0, 3));
                    cpu_wrdata = 8'($urandom);
                end
                for (int i = 0; i < int'(NUM_RD); i++) begin
                    if (!rd_strobe[i] || m_rd_ack == i) begin
                        rd_strobe[i] = ($urandom_range(0, 99) < 50);
                        rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
                    end
                end
            end
            tick();
        end
        reset = 1'b0; cpu_strobe = 1'b0; rd_strobe = '0;
        tick();
        tick();
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
